// File: rtl/sort_pkg.sv
// Shared constants for the register-file sorter feeder.
// Widths, pad value and loader state encoding.
package sort_pkg;

    localparam int DW    = 16;
    localparam int AW    = 5;
    localparam int DEPTH = 32;

    localparam logic [DW-1:0] PAD_VAL = '0;

    // Pointer is one bit wider than the RF address so it never wraps in a batch
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] PTR_LAST = (AW+1)'(DEPTH - 1);

    localparam logic [2:0] ST_LOAD    = 3'd0;
    localparam logic [2:0] ST_PAD     = 3'd1;
    localparam logic [2:0] ST_KICK    = 3'd2;
    localparam logic [2:0] ST_WAIT_HI = 3'd3;
    localparam logic [2:0] ST_WAIT_LO = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    // True when the pointer addresses the final RF entry
    function automatic logic at_last(input logic [AW:0] p);
        return p == PTR_LAST;
    endfunction

endpackage

// File: rtl/sort_loader.sv
// Batch loader in front of the 32x16 register-file sorter.
// Streams words into the RF, pads the tail, kicks the sorter, reports done.
module sort_loader
    import sort_pkg::*;
(
    input  logic          clk,
    input  logic          rstn,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic          sort_exe,
    input  logic          sort_busy,
    input  logic          sort_we,
    input  logic [AW-1:0] sort_wa,
    input  logic [DW-1:0] sort_wd,
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd,
    output logic [AW:0]   count,
    output logic          done
);

    logic [2:0]    state_q, state_d;
    logic [AW:0]   ptr_q, ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          we_q, we_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [DW-1:0] wd_q, wd_d;
    logic          xfer;

    assign in_ready = rstn && (state_q == ST_LOAD) && !sort_busy;
    assign xfer     = in_valid && in_ready;
    assign sort_exe = (state_q == ST_KICK);
    assign done     = (state_q == ST_DONE);
    assign count    = count_q;

    // Sorter owns the RF write port for as long as it reports busy
    always_comb begin
        rf_we = we_q;
        rf_wa = wa_q;
        rf_wd = wd_q;
        if (sort_busy) begin
            rf_we = sort_we;
            rf_wa = sort_wa;
            rf_wd = sort_wd;
        end
    end

    // Next-state: load, pad, kick sorter, wait for busy pulse, report done
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        we_d    = 1'b0;
        wa_d    = wa_q;
        wd_d    = wd_q;
        case (state_q)
            ST_LOAD: begin
                if (xfer) begin
                    we_d    = 1'b1;
                    wa_d    = ptr_q[AW-1:0];
                    wd_d    = in_data;
                    ptr_d   = ptr_q + PTR_ONE;
                    count_d = ptr_q + PTR_ONE;
                    if (at_last(ptr_q)) begin
                        state_d = ST_KICK;
                    end else if (in_last) begin
                        state_d = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                we_d  = 1'b1;
                wa_d  = ptr_q[AW-1:0];
                wd_d  = PAD_VAL;
                ptr_d = ptr_q + PTR_ONE;
                if (at_last(ptr_q)) begin
                    state_d = ST_KICK;
                end
            end
            ST_KICK: begin
                state_d = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (sort_busy) begin
                    state_d = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!sort_busy) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                ptr_d   = '0;
                state_d = ST_LOAD;
            end
            default: begin
                ptr_d   = '0;
                state_d = ST_LOAD;
            end
        endcase
    end

    // State and loader write-port registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= ST_LOAD;
            ptr_q   <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            we_q    <= we_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
        end
    end

endmodule

// File: tb/tb_sort_loader.sv
// Randomised bench for sort_loader with a behavioural RF and sorter.
// Batches are checked against a sorted, zero-padded model of the input.
module tb_sort_loader;
    import sort_pkg::*;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          in_valid, in_last, in_ready;
    logic [DW-1:0] in_data;
    logic          sort_exe, sort_busy, sort_we;
    logic [AW-1:0] sort_wa;
    logic [DW-1:0] sort_wd;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;
    logic [AW:0]   count;
    logic          done;

    int n_cmp = 0;
    int n_bad = 0;
    int exe_cnt = 0;
    int done_cnt = 0;
    logic prev_exe = 1'b0;
    logic prev_done = 1'b0;
    logic [DW-1:0] rf [DEPTH];
    logic [AW+DW-1:0] trace [$];

    sort_loader dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
        .in_ready(in_ready), .sort_exe(sort_exe), .sort_busy(sort_busy),
        .sort_we(sort_we), .sort_wa(sort_wa), .sort_wd(sort_wd),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
        .count(count), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Register file written through the muxed port
    always @(posedge clk) begin
        if (rf_we === 1'b1) rf[rf_wa] <= rf_wd;
    end

    // Behavioural sorter: snapshot RF after exe, write back descending
    initial begin
        logic [DW-1:0] q [$];
        sort_busy = 1'b0;
        sort_we = 1'b0;
        sort_wa = '0;
        sort_wd = '0;
        forever begin
            @(negedge clk);
            if (sort_exe) begin
                @(posedge clk);
                #1;
                q = {};
                for (int i = 0; i < DEPTH; i++) q.push_back(rf[i]);
                q.rsort();
                sort_busy = 1'b1;
                for (int i = 0; i < DEPTH; i++) begin
                    sort_we = 1'b1;
                    sort_wa = AW'(i);
                    sort_wd = q[i];
                    @(posedge clk);
                    #1;
                end
                sort_we = 1'b0;
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
                sort_busy = 1'b0;
            end
        end
    end

    // Per-cycle compare: port ownership, handshake gating, pulse widths
    always @(negedge clk) begin
        if (sort_busy) begin
            chk("mux_we", rf_we, sort_we);
            if (sort_we) begin
                chk("mux_wa", rf_wa, sort_wa);
                chk("mux_wd", rf_wd, sort_wd);
            end
            chk("ready_while_busy", in_ready, 0);
        end
        if (!rstn) chk("ready_in_reset", in_ready, 0);
        if (sort_exe) begin
            chk("exe_single_cycle", prev_exe, 0);
            exe_cnt++;
        end
        if (done) begin
            chk("done_single_cycle", prev_done, 0);
            done_cnt++;
        end
        if (rstn && rf_we && !sort_busy) trace.push_back({rf_wa, rf_wd});
        prev_exe = sort_exe;
        prev_done = done;
    end

    task automatic send(input logic [DW-1:0] w [$], input int mode);
        int idx = 0;
        int cyc = 0;
        int n = w.size();
        bit v;
        while (idx < n && cyc < 400) begin
            @(negedge clk);
            cyc++;
            case (mode)
                0: v = 1'b1;
                1: v = (cyc % 2) == 1;
                default: v = ($urandom_range(0, 1) == 1);
            endcase
            in_valid = v;
            in_data = v ? w[idx] : DW'($urandom);
            in_last = v && (idx == n - 1);
            if (v && in_ready) idx++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = DW'($urandom);
        if (idx != n) chk("send_timeout", idx, n);
    endtask

    task automatic wait_done();
        int c = 0;
        bit seen = 0;
        while (c < 300 && !seen) begin
            @(negedge clk);
            c++;
            if (done) seen = 1;
        end
        chk("done_seen", seen, 1);
    endtask

    task automatic batch(input logic [DW-1:0] w [$], input int mode);
        int e0 = exe_cnt;
        int t0 = trace.size();
        int n = w.size();
        logic [DW-1:0] m [$];
        logic [DW-1:0] ev;
        send(w, mode);
        wait_done();
        chk("count", count, n);
        chk("exe_pulses", exe_cnt - e0, 1);
        chk("loader_writes", trace.size() - t0, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            if (t0 + i < trace.size()) begin
                ev = (i < n) ? w[i] : PAD_VAL;
                chk($sformatf("wr_seq[%0d]", i), trace[t0 + i], {AW'(i), ev});
            end
        end
        m = w;
        while (m.size() < DEPTH) m.push_back(PAD_VAL);
        m.rsort();
        for (int i = 0; i < DEPTH; i++)
            chk($sformatf("rf[%0d]", i), rf[i], m[i]);
    endtask

    initial begin
        logic [DW-1:0] w [$];
        int e0;
        int d0;
        int c;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_data = '0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", in_ready, 0);
        chk("rst_exe", sort_exe, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_we", rf_we, 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", in_ready, 1);

        // Full batch, no padding
        w = {};
        for (int i = 1; i <= DEPTH; i++) w.push_back(DW'(i));
        batch(w, 0);
        chk("t1_rf0", rf[0], 16'h0020);
        chk("t1_rf31", rf[31], 16'h0001);
        chk("t1_count", count, 32);

        // Short batch with padding
        w = '{16'd7, 16'd3, 16'd9, 16'd1, 16'd5};
        batch(w, 0);
        chk("t2_rf0", rf[0], 16'd9);
        chk("t2_rf1", rf[1], 16'd7);
        chk("t2_rf4", rf[4], 16'd1);
        chk("t2_rf5", rf[5], 16'd0);
        chk("t2_rf31", rf[31], 16'd0);

        // Gappy valid, full batch
        w = {};
        for (int i = 0; i < DEPTH; i++) w.push_back(DW'($urandom));
        batch(w, 1);

        // Single word
        w = '{16'hBEEF};
        batch(w, 0);
        chk("t6_rf0", rf[0], 16'hBEEF);
        chk("t6_rf1", rf[1], 16'h0000);
        chk("t6_count", count, 1);

        // Reset during padding at ptr 12
        w = {};
        for (int i = 0; i < 12; i++) w.push_back(DW'($urandom_range(1, 65535)));
        e0 = exe_cnt;
        send(w, 0);
        rstn = 1'b0;
        @(negedge clk);
        chk("t4_ready_rst", in_ready, 0);
        chk("t4_we_rst", rf_we, 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("t4_ready", in_ready, 1);
        chk("t4_count", count, 0);
        repeat (20) @(negedge clk);
        chk("t4_no_exe", exe_cnt - e0, 0);

        // Reset while sorter busy
        w = {};
        for (int i = 0; i < 8; i++) w.push_back(DW'($urandom));
        send(w, 0);
        c = 0;
        while (!sort_busy && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("t5_busy_seen", sort_busy, 1);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        e0 = exe_cnt;
        d0 = done_cnt;
        @(negedge clk);
        chk("t5_ready_busy", in_ready, 0);
        c = 0;
        while (sort_busy && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("t5_busy_fell", sort_busy, 0);
        chk("t5_ready_after", in_ready, 1);
        repeat (10) @(negedge clk);
        chk("t5_no_exe", exe_cnt - e0, 0);
        chk("t5_no_done", done_cnt - d0, 0);

        // Random batches with random valid
        for (int b = 0; b < 6; b++) begin
            w = {};
            for (int i = 0; i < $urandom_range(1, DEPTH); i++)
                w.push_back(DW'($urandom));
            batch(w, 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
